// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity selectors and frame constants
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int FRAME_BITS_PAR   = 11;
    localparam int FRAME_BITS_NOPAR = 10;
    localparam int DEFAULT_PRESCALE = 8;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for uart_tx: counts Prescale clocks per bit and tracks
// which data bit is on the line.
module uart_tx_bit_timer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_data,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done,
    output logic                      last_data_bit
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    // prescale - 1 wraps to all-ones for prescale == 0, giving a 2**W-cycle bit.
    assign bit_done      = (cnt_q == (prescale - PRESCALE_WIDTH'(1)));
    assign last_data_bit = (idx_q == IDX_W'(DATA_WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            cnt_d = bit_done ? '0 : cnt_q + 1'b1;
            if (bit_done && in_data) begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: captures a byte on Data_Valid and serialises it LSB-first
// as start + data + optional parity + stop, Prescale clocks per bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic                      TX_OUT,
    output logic                      busy
);

    uart_state_e               state_q, state_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      par_en_q, par_en_d;
    logic                      par_bit_q, par_bit_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic bit_done;
    logic last_data_bit;
    logic timer_clear;
    logic in_data;

    assign timer_clear = (state_q == IDLE);
    assign in_data     = (state_q == DATA);

    uart_tx_bit_timer #(
        .DATA_WIDTH    (DATA_WIDTH),
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk          (CLK),
        .rst          (RST),
        .clear        (timer_clear),
        .in_data      (in_data),
        .prescale     (presc_q),
        .bit_done     (bit_done),
        .last_data_bit(last_data_bit)
    );

    // tx_d is the level for the bit being entered, so TX_OUT is a plain flop.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        presc_d   = presc_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    shift_d   = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
                    presc_d   = Prescale;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (last_data_bit) begin
                        state_d = par_en_q ? PARITY : STOP;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            presc_q   <= presc_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: compares the serial line and busy flag
// cycle by cycle against a frame model built from the UART framing rules.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_tx #(
        .DATA_WIDTH    (8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .Prescale  (Prescale),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    function automatic int eff_p(input logic [5:0] pr);
        return (pr == 6'd0) ? 64 : int'(pr);
    endfunction

    function automatic int frame_len(input logic pe);
        return pe ? 11 : 10;
    endfunction

    // Line level k clocks after the accepting edge (k = 0 is the first start-bit clock).
    function automatic logic exp_line(input logic [7:0] d, input logic pe, input logic pt,
                                      input int p, input int k);
        int b;
        b = k / p;
        if (k >= frame_len(pe) * p) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pe && b == 9) begin
            int ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(d[i]);
            return pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
        return 1'b1;
    endfunction

    // Present a request and return at the sample point just after the accepting edge.
    task automatic start_frame(input logic [7:0] d, input logic [5:0] pr, input logic pe,
                               input logic pt, input logic hold);
        P_DATA = d; Prescale = pr; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
        @(posedge CLK); #1;
        if (!hold) Data_Valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (TX_OUT !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", TX_OUT); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_directed();
        logic [7:0] d [3]  = '{8'hA5, 8'hA5, 8'h07};
        logic [5:0] pr [3] = '{6'd8, 6'd16, 6'd32};
        logic       pe [3] = '{1'b1, 1'b1, 1'b0};
        logic       pt [3] = '{1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            int p, f;
            p = eff_p(pr[t]);
            f = frame_len(pe[t]) * p;
            start_frame(d[t], pr[t], pe[t], pt[t], 1'b0);
            for (int k = 0; k <= f; k++) begin
                if (k > 0) begin @(posedge CLK); #1; end
                total++;
                if (TX_OUT !== exp_line(d[t], pe[t], pt[t], p, k)) begin
                    bad++;
                    $display("FAIL directed%0d_tx k=%0d got=%b exp=%b", t, k, TX_OUT,
                             exp_line(d[t], pe[t], pt[t], p, k));
                end
                total++;
                if (busy !== (k < f)) begin
                    bad++;
                    $display("FAIL directed%0d_busy k=%0d got=%b exp=%b", t, k, busy, k < f);
                end
            end
        end
    endtask

    task automatic test_ignore_busy();
        int p, f;
        p = 8;
        f = 10 * p;
        start_frame(8'hFF, 6'd8, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= f; k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            total++;
            if (TX_OUT !== exp_line(8'hFF, 1'b0, 1'b0, p, k)) begin
                bad++;
                $display("FAIL ignore_tx k=%0d got=%b exp=%b", k, TX_OUT,
                         exp_line(8'hFF, 1'b0, 1'b0, p, k));
            end
            total++;
            if (busy !== (k < f)) begin
                bad++; $display("FAIL ignore_busy k=%0d got=%b exp=%b", k, busy, k < f);
            end
            if (k == 20) begin
                P_DATA = 8'h55; Prescale = 6'd16; PAR_EN = 1'b1; Data_Valid = 1'b1;
            end else begin
                Data_Valid = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] choices [4] = '{6'd8, 6'd16, 6'd32, 6'd0};
        for (int t = 0; t < 6; t++) begin
            logic [7:0] d;
            logic [5:0] pr;
            logic pe, pt;
            int p, f;
            d  = 8'($urandom);
            pr = choices[$urandom_range(0, 3)];
            pe = 1'($urandom);
            pt = 1'($urandom);
            p  = eff_p(pr);
            f  = frame_len(pe) * p;
            start_frame(d, pr, pe, pt, 1'b0);
            for (int k = 0; k <= f; k++) begin
                if (k > 0) begin @(posedge CLK); #1; end
                total++;
                if (TX_OUT !== exp_line(d, pe, pt, p, k)) begin
                    bad++;
                    $display("FAIL random%0d_tx d=%h p=%0d pe=%b pt=%b k=%0d got=%b exp=%b",
                             t, d, p, pe, pt, k, TX_OUT, exp_line(d, pe, pt, p, k));
                end
                total++;
                if (busy !== (k < f)) begin
                    bad++; $display("FAIL random%0d_busy k=%0d got=%b exp=%b", t, k, busy, k < f);
                end
                // Junk on every input while the frame is in flight.
                if (k < f) begin
                    P_DATA     = 8'($urandom);
                    Prescale   = 6'($urandom);
                    PAR_EN     = 1'($urandom);
                    PAR_TYP    = 1'($urandom);
                    Data_Valid = ($urandom_range(0, 3) == 0);
                end else begin
                    Data_Valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int p, f;
        p = 8;
        f = 10 * p;
        start_frame(8'h3C, 6'd8, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k <= f; k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            total++;
            if (TX_OUT !== exp_line(8'h3C, 1'b0, 1'b0, p, k)) begin
                bad++;
                $display("FAIL b2b1_tx k=%0d got=%b exp=%b", k, TX_OUT,
                         exp_line(8'h3C, 1'b0, 1'b0, p, k));
            end
            total++;
            if (busy !== (k < f)) begin
                bad++; $display("FAIL b2b1_busy k=%0d got=%b exp=%b", k, busy, k < f);
            end
            if (k == 30) P_DATA = 8'hC3;
        end
        for (int k = 0; k <= f; k++) begin
            @(posedge CLK); #1;
            total++;
            if (TX_OUT !== exp_line(8'hC3, 1'b0, 1'b0, p, k)) begin
                bad++;
                $display("FAIL b2b2_tx k=%0d got=%b exp=%b", k, TX_OUT,
                         exp_line(8'hC3, 1'b0, 1'b0, p, k));
            end
            total++;
            if (busy !== (k < f)) begin
                bad++; $display("FAIL b2b2_busy k=%0d got=%b exp=%b", k, busy, k < f);
            end
            if (k == 5) Data_Valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        start_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= 35; k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            total++;
            if (TX_OUT !== exp_line(8'hA5, 1'b0, 1'b0, 8, k)) begin
                bad++;
                $display("FAIL rstmid_tx k=%0d got=%b exp=%b", k, TX_OUT,
                         exp_line(8'hA5, 1'b0, 1'b0, 8, k));
            end
        end
        #2 RST = 1'b1;
        #1;
        total++;
        if (TX_OUT !== 1'b1) begin bad++; $display("FAIL rst_async_tx got=%b exp=1", TX_OUT); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
        Data_Valid = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL rst_hold_busy got=%b exp=0", busy); end
        end
        Data_Valid = 1'b0;
        RST = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge CLK); #1;
            total++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL post_rst_idle k=%0d got tx=%b busy=%b exp tx=1 busy=0", k, TX_OUT, busy);
            end
        end
        d = 8'($urandom);
        start_frame(d, 6'd16, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k <= 176; k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            total++;
            if (TX_OUT !== exp_line(d, 1'b1, 1'b1, 16, k) || busy !== (k < 176)) begin
                bad++;
                $display("FAIL recover k=%0d got tx=%b busy=%b exp tx=%b busy=%b", k, TX_OUT, busy,
                         exp_line(d, 1'b1, 1'b1, 16, k), k < 176);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter; the transmit-side counterpart of the UART receiver already in the System/UART tree.
- Accepts one parallel byte per handshake and serialises it LSB-first as start + 8 data + optional parity + stop.
- Runs on the same oversampled clock as the receiver (TX baud × Prescale), so both ends of the UART share one clock domain and one Prescale setting.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale input.

Ports:
- CLK  input  1  oversampled UART clock (baud × Prescale).
- RST  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel byte to send.
- Data_Valid  input  1  request strobe; qualifies P_DATA, PAR_EN, PAR_TYP and Prescale.
- Prescale  input  PRESCALE_WIDTH  clocks per bit; 8/16/32 supported.
- PAR_EN  input  1  1 = append parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- TX_OUT  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight.

Behaviour:
- Clocking and reset: one clock (CLK); reset is asynchronous and active-high (RST).
- Reset values: TX_OUT=1, busy=0, state=IDLE, bit counter=0, bit index=0, shift register=0.
- Reset mid-frame: TX_OUT=1 and busy=0 immediately on RST assertion; the frame is abandoned and nothing resumes after release.
- All outputs are registered; TX_OUT is glitch-free.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0.
  - Data_Valid=1 at rising edge N captures P_DATA, PAR_EN, PAR_TYP and Prescale into internal registers.
  - After edge N: state=START, TX_OUT=0, busy=1.
- Bit period: P = captured Prescale. Prescale=0 is treated as 64.
  - A cycle counter counts 0..P-1.
  - The state or bit advances on the edge where the counter equals P-1; the counter then wraps to 0.
- START: TX_OUT=0 for P cycles, then go to DATA with bit index 0.
- DATA: TX_OUT = captured data[index] for P cycles per bit, index 0..7.
  - After index 7: go to PARITY if PAR_EN, else STOP.
- PARITY: TX_OUT = ^data when PAR_TYP=0, ~^data when PAR_TYP=1, for P cycles; then go to STOP.
- STOP: TX_OUT=1 for P cycles; then go to IDLE with busy=0.
- Frame length F = 11 bits with parity, 10 without.
  - TX_OUT=0 from edge N.
  - TX_OUT returns to idle and busy=0 after edge N+F·P.
- Data_Valid while busy=1 is ignored: no queuing, no corruption of the captured byte.
- Input changes during a frame (P_DATA, PAR_EN, PAR_TYP, Prescale) have no effect on the current frame.
- Back-to-back frames:
  - Data_Valid may be held high continuously.
  - The next frame is accepted on the first IDLE edge, giving exactly one idle-high clock between the stop bit and the next start bit.
- Data_Valid and reset release on the same edge: reset wins; the request is not taken.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum, shared with the receiver's constants.
  - PAR_EVEN=0 and PAR_ODD=1.
  - FRAME_BITS_PAR=11 and FRAME_BITS_NOPAR=10.
  - DEFAULT_PRESCALE=8.
- One sub-module, uart_tx_bit_timer:
  - Holds the Prescale cycle counter and bit index.
  - Outputs a bit_done pulse and a last_data_bit flag.
  - Takes a clear input from the FSM.
- Parity and the output mux stay inline in uart_tx.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit held 8 clocks; busy high for 88 clocks.
- Prescale=16, PAR_EN=1, PAR_TYP=1, P_DATA=0xA5 -> parity bit = 1; frame spans 176 clocks; a loopback through the UART receiver yields P_DATA=0xA5 with data_valid pulsed.
- Prescale=32, PAR_EN=0, P_DATA=0x07 -> 10-bit frame 0,1,1,1,0,0,0,0,0,1 over 320 clocks; no parity bit emitted.
- Data_Valid held high with P_DATA 0x3C then 0xC3 (Prescale=8, no parity) -> two frames separated by exactly one idle-high clock; a P_DATA change mid-frame does not alter frame 1.
- Data_Valid pulse with 0x55 at clock 20 of a 0xFF frame -> ignored; only 0xFF transmitted.
- RST asserted during the DATA bit-3 period -> TX_OUT=1 and busy=0 asynchronously; after release, the line stays idle until a new Data_Valid arrives.
